// File: rtl/frame_config_sequencer_if.sv
// Bitstream-side stream and column-side frame outputs of the frame sequencer.
interface frame_config_sequencer_if #(
    parameter int MaxFramesPerCol = 20,
    parameter int FrameBitsPerRow = 32,
    parameter int NumRows         = 4
);
    localparam int IdxW = $clog2(MaxFramesPerCol);

    logic                                 start;
    logic                                 abort;
    logic                                 s_valid;
    logic                                 s_ready;
    logic [FrameBitsPerRow-1:0]           s_data;
    logic [NumRows*FrameBitsPerRow-1:0]   FrameData;
    logic [MaxFramesPerCol-1:0]           FrameStrobe;
    logic [IdxW-1:0]                      frame_idx;
    logic                                 busy;
    logic                                 done;

    modport slave (
        input  start, abort, s_valid, s_data,
        output s_ready, FrameData, FrameStrobe, frame_idx, busy, done
    );

    modport master (
        output start, abort, s_valid, s_data,
        input  s_ready, FrameData, FrameStrobe, frame_idx, busy, done
    );
endinterface

// File: rtl/frame_config_sequencer.sv
// Assembles NumRows words into one frame, then strobes that frame into the
// column with a one-cycle hold gap, for every frame of the column.
module frame_config_sequencer #(
    parameter int MaxFramesPerCol = 20,
    parameter int FrameBitsPerRow = 32,
    parameter int NumRows         = 4
) (
    input  logic                     UserCLK,
    input  logic                     resetn,
    frame_config_sequencer_if.slave  bus
);
    localparam int IdxW = $clog2(MaxFramesPerCol);
    localparam int RowW = (NumRows > 1) ? $clog2(NumRows) : 1;

    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_STROBE, S_HOLD, S_DONE} state_t;

    state_t                             r_state;
    state_t                             w_next;
    logic [RowW-1:0]                    r_row;
    logic [IdxW-1:0]                    r_idx;
    logic [NumRows*FrameBitsPerRow-1:0] r_data;
    logic [MaxFramesPerCol-1:0]         r_strobe;
    logic                               r_busy;
    logic                               r_done;
    logic                               w_ready;
    logic                               w_accept;
    logic                               w_last_row;
    logic                               w_last_frame;

    // abort gates s_ready so a word offered alongside it is never consumed
    assign w_ready      = (r_state == S_LOAD) && !bus.abort;
    assign w_accept     = w_ready && bus.s_valid;
    assign w_last_row   = (r_row == RowW'(NumRows - 1));
    assign w_last_frame = (r_idx == IdxW'(MaxFramesPerCol - 1));

    // Next-state decode; abort overrides every other input
    always_comb begin
        w_next = r_state;
        if (bus.abort) begin
            w_next = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE:   if (bus.start) w_next = S_LOAD;
                S_LOAD:   if (w_accept && w_last_row) w_next = S_STROBE;
                S_STROBE: w_next = S_HOLD;
                S_HOLD:   w_next = w_last_frame ? S_DONE : S_LOAD;
                S_DONE:   w_next = S_IDLE;
                default:  w_next = S_IDLE;
            endcase
        end
    end

    // State, counters and registered outputs; reset and abort clear identically
    always_ff @(posedge UserCLK) begin
        if (!resetn || bus.abort) begin
            r_state  <= S_IDLE;
            r_row    <= '0;
            r_idx    <= '0;
            r_data   <= '0;
            r_strobe <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_state  <= w_next;
            r_busy   <= (w_next != S_IDLE);
            r_done   <= (w_next == S_DONE);
            // frame index is stable from LOAD through HOLD, so it selects the strobe
            r_strobe <= (w_next == S_STROBE) ? (MaxFramesPerCol'(1) << r_idx) : '0;
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_idx <= '0;
                        r_row <= '0;
                    end
                end
                S_LOAD: begin
                    if (w_accept) begin
                        r_data[r_row*FrameBitsPerRow +: FrameBitsPerRow] <= bus.s_data;
                        r_row <= w_last_row ? '0 : r_row + 1'b1;
                    end
                end
                S_HOLD: begin
                    if (!w_last_frame) r_idx <= r_idx + 1'b1;
                end
                S_DONE: begin
                    r_idx <= '0;
                end
                default: ;
            endcase
        end
    end

    assign bus.s_ready     = w_ready;
    assign bus.FrameData   = r_data;
    assign bus.FrameStrobe = r_strobe;
    assign bus.frame_idx   = r_idx;
    assign bus.busy        = r_busy;
    assign bus.done        = r_done;
endmodule

// File: tb/tb_frame_config_sequencer.sv
// Bench for frame_config_sequencer: directed vector table, directed corner
// sequences and random traffic, all checked against a word/frame-level model.
module tb_frame_config_sequencer;
    localparam int MF = 20;
    localparam int W  = 32;
    localparam int NR = 4;

    logic clk;
    logic rstn;
    int   checks = 0;
    int   fails  = 0;

    frame_config_sequencer_if #(.MaxFramesPerCol(MF), .FrameBitsPerRow(W), .NumRows(NR)) bif ();

    frame_config_sequencer #(.MaxFramesPerCol(MF), .FrameBitsPerRow(W), .NumRows(NR)) dut (
        .UserCLK (clk),
        .resetn  (rstn),
        .bus     (bif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: column progress as words-per-frame, frame number and a
    // post-frame phase (0 loading, 1 strobe, 2 hold, 3 done).
    bit          m_active;
    int          m_frame, m_rows, m_post;
    logic [31:0] m_fd [NR];
    bit          pre_rdy;
    bit          last_acc;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [127:0] m_pack();
        logic [127:0] v;
        for (int r = 0; r < NR; r++) v[r*W +: W] = m_fd[r];
        return v;
    endfunction

    task automatic model_clear();
        m_active = 0; m_frame = 0; m_rows = 0; m_post = 0;
        for (int r = 0; r < NR; r++) m_fd[r] = '0;
    endtask

    task automatic model_update(input bit st, input bit ab, input bit v, input logic [31:0] d, input bit rn);
        if (!rn || ab) begin
            model_clear();
        end else if (!m_active) begin
            if (st) begin
                m_active = 1; m_frame = 0; m_rows = 0; m_post = 0;
            end
        end else begin
            case (m_post)
                0: if (v) begin
                    m_fd[m_rows] = d;
                    m_rows++;
                    if (m_rows == NR) begin m_rows = 0; m_post = 1; end
                end
                1: m_post = 2;
                2: if (m_frame == MF - 1) m_post = 3;
                   else begin m_frame++; m_post = 0; end
                default: begin m_active = 0; m_frame = 0; m_post = 0; end
            endcase
        end
    endtask

    // One clock: drive after negedge, check s_ready, clock, check registered outputs
    task automatic step(input bit st, input bit ab, input bit v, input logic [31:0] d, input bit rn);
        logic [19:0] e_stb;
        bif.start = st; bif.abort = ab; bif.s_valid = v; bif.s_data = d; rstn = rn;
        #1;
        pre_rdy = m_active && (m_post == 0) && !ab;
        chk("s_ready", bif.s_ready, pre_rdy);
        last_acc = rn && v && pre_rdy;
        @(posedge clk);
        model_update(st, ab, v, d, rn);
        @(negedge clk);
        e_stb = (m_active && m_post == 1) ? (20'd1 << m_frame) : 20'd0;
        chk("busy", bif.busy, m_active);
        chk("done", bif.done, m_active && m_post == 3);
        chk("strobe", bif.FrameStrobe, e_stb);
        chk("frame_idx", bif.frame_idx, m_frame);
        chk("frame_data", bif.FrameData, m_pack());
    endtask

    // Stream words until the model reaches the given frame/phase/row position
    task automatic load_until(input int fr, input int post, input int rows);
        int guard = 0;
        while (!(m_frame == fr && m_post == post && m_rows == rows) && guard < 500) begin
            step(0, 0, 1, 32'h1000 + guard, 1);
            guard++;
        end
        chk("seq_timeout", guard < 500, 1);
    endtask

    // Full column with 'gap' idle cycles of s_valid after every accepted word
    task automatic run_column(input int gap);
        int k = 0, n = 0, cyc = 0, g = 0;
        bit seen = 0;
        logic [19:0]  one;
        logic [127:0] e;
        step(0, 1, 0, 0, 1);
        step(1, 0, 0, 0, 1);
        while (!seen && cyc < 2000) begin
            step(0, 0, g == 0, n, 1);
            cyc++;
            if (last_acc) begin n++; g = gap; end
            else if (g > 0) g--;
            if (bif.FrameStrobe != '0) begin
                one = 20'd1 << k;
                for (int r = 0; r < NR; r++) e[r*W +: W] = 4 * k + r;
                chk("col_strobe_order", bif.FrameStrobe, one);
                chk("col_strobe_data", bif.FrameData, e);
                k++;
            end
            if (bif.done) begin
                seen = 1;
                if (gap == 0) chk("col_done_cycle", cyc, 120);
            end
        end
        chk("col_strobe_count", k, MF);
        chk("col_done_seen", seen, 1);
        step(0, 0, 0, 0, 1);
        chk("col_busy_after_done", bif.busy, 0);
    endtask

    typedef struct {
        bit st, ab, v, rn;
        logic [31:0] d;
        bit e_rdy, e_busy;
        logic [19:0] e_stb;
        logic [4:0]  e_idx;
        logic [31:0] e_row0;
    } vec_t;

    function automatic vec_t mk(bit st, bit ab, bit v, bit rn, logic [31:0] d,
                                bit e_rdy, bit e_busy, logic [19:0] e_stb,
                                logic [4:0] e_idx, logic [31:0] e_row0);
        vec_t t;
        t.st = st; t.ab = ab; t.v = v; t.rn = rn; t.d = d;
        t.e_rdy = e_rdy; t.e_busy = e_busy; t.e_stb = e_stb; t.e_idx = e_idx; t.e_row0 = e_row0;
        return t;
    endfunction

    vec_t tbl [16];

    initial begin
        int scount;
        //         st ab v rn data    rdy busy stb  idx row0
        tbl[0]  = mk(0, 0, 0, 0, 32'h0,  0, 0, 20'h0, 0, 32'h0);
        tbl[1]  = mk(1, 1, 0, 1, 32'h0,  0, 0, 20'h0, 0, 32'h0);
        tbl[2]  = mk(1, 0, 0, 1, 32'h0,  0, 1, 20'h0, 0, 32'h0);
        tbl[3]  = mk(0, 0, 1, 1, 32'hA0, 1, 1, 20'h0, 0, 32'hA0);
        tbl[4]  = mk(0, 0, 1, 1, 32'hA1, 1, 1, 20'h0, 0, 32'hA0);
        tbl[5]  = mk(0, 0, 1, 1, 32'hA2, 1, 1, 20'h0, 0, 32'hA0);
        tbl[6]  = mk(0, 0, 1, 1, 32'hA3, 1, 1, 20'h1, 0, 32'hA0);
        tbl[7]  = mk(1, 0, 1, 1, 32'hFF, 0, 1, 20'h0, 0, 32'hA0);
        tbl[8]  = mk(0, 0, 1, 1, 32'hFF, 0, 1, 20'h0, 1, 32'hA0);
        tbl[9]  = mk(0, 0, 1, 1, 32'hB0, 1, 1, 20'h0, 1, 32'hB0);
        tbl[10] = mk(1, 0, 1, 1, 32'hB1, 1, 1, 20'h0, 1, 32'hB0);
        tbl[11] = mk(0, 1, 1, 1, 32'hB2, 0, 0, 20'h0, 0, 32'h0);
        tbl[12] = mk(1, 1, 0, 1, 32'h0,  0, 0, 20'h0, 0, 32'h0);
        tbl[13] = mk(1, 0, 0, 1, 32'h0,  0, 1, 20'h0, 0, 32'h0);
        tbl[14] = mk(0, 0, 1, 1, 32'hC0, 1, 1, 20'h0, 0, 32'hC0);
        tbl[15] = mk(0, 0, 1, 0, 32'hC1, 1, 0, 20'h0, 0, 32'h0);

        bif.start = 0; bif.abort = 0; bif.s_valid = 0; bif.s_data = '0; rstn = 0;
        model_clear();
        @(negedge clk);
        @(posedge clk);
        @(negedge clk);

        // Directed vector table
        for (int i = 0; i < 16; i++) begin
            step(tbl[i].st, tbl[i].ab, tbl[i].v, tbl[i].d, tbl[i].rn);
            chk($sformatf("tbl%0d_rdy", i), pre_rdy, tbl[i].e_rdy);
            chk($sformatf("tbl%0d_busy", i), bif.busy, tbl[i].e_busy);
            chk($sformatf("tbl%0d_stb", i), bif.FrameStrobe, tbl[i].e_stb);
            chk($sformatf("tbl%0d_idx", i), bif.frame_idx, tbl[i].e_idx);
            chk($sformatf("tbl%0d_row0", i), bif.FrameData[31:0], tbl[i].e_row0);
            chk($sformatf("tbl%0d_done", i), bif.done, 0);
        end

        // Nominal column and backpressured column
        run_column(0);
        run_column(3);

        // Abort after two words of frame 5, then restart from frame 0
        step(1, 0, 0, 0, 1);
        load_until(5, 0, 2);
        step(0, 1, 1, 32'hDEAD, 1);
        chk("abort_strobe", bif.FrameStrobe, 0);
        chk("abort_data", bif.FrameData, 0);
        chk("abort_busy", bif.busy, 0);
        chk("abort_idx", bif.frame_idx, 0);
        chk("abort_done", bif.done, 0);
        step(1, 0, 0, 0, 1);
        step(0, 0, 1, 32'hCAFE, 1);
        chk("restart_idx", bif.frame_idx, 0);
        chk("restart_row0", bif.FrameData[31:0], 32'hCAFE);

        // Abort while FrameStrobe[3] is high
        step(0, 1, 0, 0, 1);
        step(1, 0, 0, 0, 1);
        load_until(3, 1, 0);
        chk("strobe3_live", bif.FrameStrobe, 20'h8);
        step(0, 1, 1, 32'h5, 1);
        chk("strobe_abort_stb", bif.FrameStrobe, 0);
        chk("strobe_abort_busy", bif.busy, 0);
        scount = 0;
        for (int i = 0; i < 8; i++) begin
            step(0, 0, 1, i, 1);
            if (bif.FrameStrobe != '0) scount++;
        end
        chk("strobe_abort_no_more", scount, 0);

        // Synchronous reset during HOLD of frame 10
        step(1, 0, 0, 0, 1);
        load_until(10, 2, 0);
        chk("hold10_busy", bif.busy, 1);
        step(0, 0, 1, 32'h77, 0);
        chk("rst_busy", bif.busy, 0);
        chk("rst_data", bif.FrameData, 0);
        chk("rst_idx", bif.frame_idx, 0);
        chk("rst_stb", bif.FrameStrobe, 0);
        for (int i = 0; i < 4; i++) begin
            step(0, 0, 1, i, 1);
            chk("rst_ready_low", pre_rdy, 0);
        end

        // Random traffic against the model
        for (int i = 0; i < 4000; i++) begin
            step($urandom_range(0, 7) == 0, $urandom_range(0, 149) == 0,
                 $urandom_range(0, 2) != 0, $urandom, $urandom_range(0, 299) != 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end
endmodule
